// File: rtl/av_sprite_fetch_arbiter_if.sv
// Sprite fetch bus between the string renderers, the arbiter and the sprite ROM bank.
// master = renderer/ROM side, slave = arbiter.
interface av_sprite_fetch_arbiter_if #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 4,
  parameter int DATA_W = 13
) ();
  // req[i] is the valid and gnt[i] the ready of channel i; a read transfers on
  // every edge where req[i] & gnt[i]. req/addr/sel stay stable until granted.
  logic                       enable;
  logic [NUM_CH-1:0]          req;
  logic [NUM_CH*ADDR_W-1:0]   req_addr;
  logic [NUM_CH*SEL_W-1:0]    req_sel;
  logic [NUM_CH-1:0]          gnt;
  logic                       rom_en;
  logic [ADDR_W-1:0]          rom_addr;
  logic [SEL_W-1:0]           rom_sel;
  logic [DATA_W-1:0]          rom_data;
  logic [NUM_CH-1:0]          rsp_valid;
  logic [DATA_W-1:0]          rsp_data;

  modport master (
    output enable, req, req_addr, req_sel, rom_data,
    input  gnt, rom_en, rom_addr, rom_sel, rsp_valid, rsp_data
  );

  modport slave (
    input  enable, req, req_addr, req_sel, rom_data,
    output gnt, rom_en, rom_addr, rom_sel, rsp_valid, rsp_data
  );
endinterface

// File: rtl/av_sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite ROM bank among NUM_CH string renderers,
// with a pipelined read and a one-hot tag steering each pixel back to its requester.
module av_sprite_fetch_arbiter #(
  parameter int NUM_CH  = 6,
  parameter int ADDR_W  = 10,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 13,
  parameter int ROM_LAT = 2,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic                 clk65,
  input  logic                 reset,
  av_sprite_fetch_arbiter_if.slave bus,
  output logic [PTR_W-1:0]     dbg_ptr
);

  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [NUM_CH-1:0] gnt;
  logic              found;
  logic [ADDR_W-1:0] gnt_addr;
  logic [SEL_W-1:0]  gnt_sel;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [SEL_W-1:0]  rom_sel_q;
  logic [NUM_CH-1:0] rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  // tag_q[0] is loaded with rom_en; tag_q[ROM_LAT] lines up with rom_data.
  logic [NUM_CH-1:0] tag_q [ROM_LAT+1];

  // Priority scan starting at ptr_q, wrapping modulo NUM_CH.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (bus.enable && !reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && ((int'(ptr_q) + k) % NUM_CH == i) && bus.req[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    gnt_addr = '0;
    gnt_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        ptr_d    = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
        gnt_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        gnt_sel  = bus.req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      rom_en_q <= found;
      tag_q[0] <= gnt;
      if (found) begin
        ptr_q      <= ptr_d;
        rom_addr_q <= gnt_addr;
        rom_sel_q  <= gnt_sel;
      end
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= tag_q[ROM_LAT];
      // Hold the last pixel between responses.
      if (|tag_q[ROM_LAT]) rsp_data_q <= bus.rom_data;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_sel   = rom_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: doc/av_sprite_fetch_arbiter.md
Name: av_sprite_fetch_arbiter

Overview:
- Shares one sprite BRAM bank (fret sprites, 16 × 1024 × 13 bit) among NUM_CH string renderers.
- Replaces the OR-combined sprite address bus. The old bus only worked while at most one string drove a non-zero address.
- Provides a round-robin request/grant port, a pipelined ROM read, and a response steered back to the requesting channel by a one-hot tag.
- Sits between the AV_string instances and the sprite ROMs, inside the AV top level, in the clk65 domain.

Parameters:
- NUM_CH, 6: number of requesting channels (strings), 2..16.
- ADDR_W, 10: sprite pixel address width.
- SEL_W, 4: sprite index width (selects the fret_NN image).
- DATA_W, 13: sprite pixel width (12-bit RGB plus 1-bit transparency).
- ROM_LAT, 2: ROM read latency in cycles, from the rom_en sample edge to valid rom_data, 1..4.

Ports:
- clk65  in  1  pixel clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants are issued; in-flight reads still complete.
- req  in  NUM_CH  per-channel request level.
- req_addr  in  NUM_CH*ADDR_W  per-channel pixel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_sel  in  NUM_CH*SEL_W  per-channel sprite index, packed the same way.
- gnt  out  NUM_CH  one-hot combinational grant.
- rom_en  out  1  registered ROM read strobe.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_sel  out  SEL_W  registered sprite index.
- rom_data  in  DATA_W  ROM read data.
- rsp_valid  out  NUM_CH  registered one-hot response strobe.
- rsp_data  out  DATA_W  registered response pixel.

Behaviour:
- Reset (asynchronous, any time): ptr=0; rom_en=0, rom_addr=0, rom_sel=0; rsp_valid=0, rsp_data=0; tag pipeline cleared.
  - In-flight reads are discarded: no rsp_valid is produced for them after reset deasserts.
- Arbitration (combinational, per cycle):
  - If enable=1 and req≠0, gnt is one-hot on the first set req bit, scanning from index ptr upward with wrap-around modulo NUM_CH.
  - Otherwise gnt=0.
  - gnt never asserts during reset.
- ptr update: on an edge where gnt[i]=1, ptr ← (i+1) mod NUM_CH. ptr holds when there is no grant.
- Fairness: a continuously requesting channel is granted within NUM_CH cycles, provided enable stays high.
- Handshake:
  - A channel holds req, req_addr and req_sel stable until it sees gnt.
  - Transfer occurs on the edge where req[i]&gnt[i].
  - After the grant the channel may keep req high with a new address; each granted edge is one independent read.
  - Dropping req before gnt cancels the request with no side effects.
- Issue stage: on a granted edge, rom_en←1, rom_addr←req_addr[i], rom_sel←req_sel[i], and tag[0]←one-hot(i). Otherwise rom_en←0, rom_addr/rom_sel hold, and tag[0]←0.
- Tag pipeline: ROM_LAT registers deep, aligned so that the tag reaches the output on the same edge that rom_data is captured.
- Response stage: rom_data is captured into rsp_data, and rsp_valid is set to the tag, on edge T+2+ROM_LAT, where T is the grant cycle.
  - With ROM_LAT=2, gnt in cycle 0 gives rsp_valid high during cycle 4, for exactly one cycle per read.
  - rsp_data holds its last value when rsp_valid=0.
- Throughput: one read per cycle, fully pipelined, no bubbles between back-to-back grants.
- Multiple reads may be outstanding for one channel. Responses return in grant order.
- enable falling mid-burst: the current cycle's grant is suppressed combinationally; already-issued reads complete normally.
- Invalid sel/addr values are passed through unchecked.

Test Plan:
- Reset then single request: req=6'b000100, addr=10'd37, sel=4'd5 held 1 cycle; ROM model returns {sel,addr}-derived data. Required: gnt=000100 in cycle 0, rom_en=1 with addr 37 / sel 5 in cycle 1, rsp_valid=000100 in cycle 4 with the matching data. ptr=3 afterward.
- All six channels requesting continuously for 12 cycles from ptr=0: grants in order ch0,1,2,3,4,5,0,1,…, one per cycle. Each rsp_valid bit seen exactly twice, with correct per-channel data and no gaps.
- Wrap-around: ptr=5, req=6'b100001. Grants go ch5 then ch0, and ptr ends at 1.
- enable=0 for 3 cycles with req=6'b111111 while 2 reads are in flight: gnt=0 during the window; both in-flight rsp_valid pulses still appear. Grants resume at the saved ptr.
- Reset asserted asynchronously, mid-clock, with 2 reads in flight: all outputs go to 0 immediately. No rsp_valid appears after release; the first post-reset grant goes to the lowest requesting index.
- ROM_LAT=1 and ROM_LAT=4 builds with NUM_CH=3: response latency is 3 and 6 cycles respectively; round-robin order is unchanged.
